// File: rtl/mem_responder_if.sv
// Processor <-> memory request/response bundle for mem_responder.
// master = requester side, slave = memory side.
interface mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    input  mem2proc_response,
    input  mem2proc_data,
    input  mem2proc_tag
  );

  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    output mem2proc_response,
    output mem2proc_data,
    output mem2proc_tag
  );
endinterface

// File: rtl/mem_responder.sv
// Tagged fixed-latency memory model: accepts one aligned load/store per cycle,
// returns load data LATENCY cycles later, optionally throttles GAP cycles after each accept.
module mem_responder #(
  parameter int unsigned MEM_LINES = 8192,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned GAP       = 0
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave mem_bus
);

  localparam int unsigned AW = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam logic [1:0] BusLoad  = 2'd1;
  localparam logic [1:0] BusStore = 2'd2;

  typedef enum logic {StReady, StThrottle} state_e;

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_gap, w_gap_nxt;
  logic [3:0]  r_tag_cnt;

  logic [63:0] r_mem [MEM_LINES];

  logic [LATENCY-1:0] r_vld;
  logic [3:0]         r_tag [LATENCY];
  logic [63:0]        r_dat [LATENCY];

  logic [28:0]   w_line;
  logic [AW-1:0] w_idx;
  logic          w_aligned, w_in_range, w_is_load, w_is_store, w_accept, w_ret_vld;

  assign w_line     = mem_bus.proc2mem_addr[31:3];
  assign w_idx      = w_line[AW-1:0];
  assign w_aligned  = (mem_bus.proc2mem_addr[2:0] == 3'b000);
  assign w_in_range = ({3'b000, w_line} < MEM_LINES);
  assign w_is_load  = (mem_bus.proc2mem_command == BusLoad);
  assign w_is_store = (mem_bus.proc2mem_command == BusStore);
  // Gating with reset keeps the response at 0 while reset is held, independent of the clock.
  assign w_accept   = reset && (w_is_load || w_is_store) && w_aligned && w_in_range &&
                      (r_state == StReady);

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    unique case (r_state)
      StReady: begin
        if (w_accept && (GAP > 0)) begin
          w_state_nxt = StThrottle;
          w_gap_nxt   = 3'(GAP);
        end
      end
      StThrottle: begin
        w_gap_nxt = r_gap - 3'd1;
        if (r_gap <= 3'd1) w_state_nxt = StReady;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StReady;
      r_gap     <= 3'd0;
      r_tag_cnt <= 4'd1;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      if (w_accept) r_tag_cnt <= (r_tag_cnt == 4'd15) ? 4'd1 : r_tag_cnt + 4'd1;
    end
  end

  // Storage is deliberately not reset so contents survive reset and can be preloaded.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_store) r_mem[w_idx] <= mem_bus.proc2mem_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i] <= 4'd0;
        r_dat[i] <= 64'd0;
      end
    end else begin
      r_vld[0] <= w_accept && w_is_load;
      r_tag[0] <= r_tag_cnt;
      r_dat[0] <= r_mem[w_idx];
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign w_ret_vld                 = reset && r_vld[LATENCY-1];
  assign mem_bus.mem2proc_response = w_accept ? r_tag_cnt : 4'd0;
  assign mem_bus.mem2proc_tag      = w_ret_vld ? r_tag[LATENCY-1] : 4'd0;
  assign mem_bus.mem2proc_data     = w_ret_vld ? r_dat[LATENCY-1] : 64'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut1 (LATENCY=4, GAP=0) covers store/load, back-to-back, wrap, reset;
// dut2 (MEM_LINES=16, LATENCY=2, GAP=2) covers throttling and address rejection.
module tb_mem_responder;
  localparam logic [1:0] CmdNone  = 2'd0;
  localparam logic [1:0] CmdLoad  = 2'd1;
  localparam logic [1:0] CmdStore = 2'd2;
  localparam logic [1:0] CmdRsvd  = 2'd3;
  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D2 = 64'hCAFE_F00D_1234_5678;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder_if bus1 ();
  mem_responder_if bus2 ();

  mem_responder #(.MEM_LINES(8192), .LATENCY(4), .GAP(0)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .mem_bus (bus1.slave)
  );

  mem_responder #(.MEM_LINES(16), .LATENCY(2), .GAP(2)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .mem_bus (bus2.slave)
  );

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic        chk_dat;
  } vec_t;

  // dut2 script: one row per cycle, store data is always D2.
  vec_t vecs [13] = '{
    '{CmdStore, 32'h08, 4'd1, 4'd0, 1'b0},
    '{CmdLoad,  32'h08, 4'd0, 4'd0, 1'b0},
    '{CmdLoad,  32'h08, 4'd0, 4'd0, 1'b0},
    '{CmdLoad,  32'h08, 4'd2, 4'd0, 1'b0},
    '{CmdLoad,  32'h08, 4'd0, 4'd0, 1'b0},
    '{CmdNone,  32'h00, 4'd0, 4'd2, 1'b1},
    '{CmdRsvd,  32'h08, 4'd0, 4'd0, 1'b0},
    '{CmdLoad,  32'h44, 4'd0, 4'd0, 1'b0},
    '{CmdLoad,  32'h80, 4'd0, 4'd0, 1'b0},
    '{CmdLoad,  32'h78, 4'd3, 4'd0, 1'b0},
    '{CmdNone,  32'h00, 4'd0, 4'd0, 1'b0},
    '{CmdNone,  32'h00, 4'd0, 4'd3, 1'b0},
    '{CmdNone,  32'h00, 4'd0, 4'd0, 1'b0}
  };

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step1(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus1.proc2mem_command = cmd;
    bus1.proc2mem_addr    = addr;
    bus1.proc2mem_data    = data;
    #1;
  endtask

  task automatic step2(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus2.proc2mem_command = cmd;
    bus2.proc2mem_addr    = addr;
    bus2.proc2mem_data    = data;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus1.proc2mem_command = CmdNone;
    bus2.proc2mem_command = CmdNone;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [63:0] line_dat(input int i);
    return 64'h0123_4567_89AB_CDE0 + 64'(i) * 64'h1111;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus1.proc2mem_command = CmdNone;
    bus1.proc2mem_addr    = 32'd0;
    bus1.proc2mem_data    = 64'd0;
    bus2.proc2mem_command = CmdNone;
    bus2.proc2mem_addr    = 32'd0;
    bus2.proc2mem_data    = 64'd0;

    // Reset state: load presented while reset is low must not be accepted.
    @(negedge clk);
    bus1.proc2mem_command = CmdLoad;
    bus1.proc2mem_addr    = 32'h40;
    #1;
    check_eq("rst_resp", 64'(bus1.mem2proc_response), 64'd0);
    check_eq("rst_tag", 64'(bus1.mem2proc_tag), 64'd0);
    check_eq("rst_data", bus1.mem2proc_data, 64'd0);
    @(negedge clk);
    bus1.proc2mem_command = CmdNone;
    reset = 1'b1;

    // Store then load, same line.
    step1(CmdStore, 32'h40, D1);
    check_eq("st_resp", 64'(bus1.mem2proc_response), 64'd1);
    step1(CmdLoad, 32'h40, 64'd0);
    check_eq("ld_resp", 64'(bus1.mem2proc_response), 64'd2);
    for (int k = 1; k <= 5; k++) begin
      step1(CmdNone, 32'd0, 64'd0);
      if (k == 4) begin
        check_eq("ret_tag", 64'(bus1.mem2proc_tag), 64'd2);
        check_eq("ret_data", bus1.mem2proc_data, D1);
      end else begin
        check_eq($sformatf("idle_tag_%0d", k), 64'(bus1.mem2proc_tag), 64'd0);
        check_eq($sformatf("idle_data_%0d", k), bus1.mem2proc_data, 64'd0);
      end
    end

    // Back-to-back loads of lines preloaded by stores that survive reset.
    for (int i = 0; i < 4; i++) step1(CmdStore, 32'(i * 8), line_dat(i));
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c < 4) step1(CmdLoad, 32'(c * 8), 64'd0);
      else step1(CmdNone, 32'd0, 64'd0);
      if (c < 4) check_eq($sformatf("b2b_resp_%0d", c), 64'(bus1.mem2proc_response), 64'(c + 1));
      if (c >= 4 && c < 8) begin
        check_eq($sformatf("b2b_tag_%0d", c), 64'(bus1.mem2proc_tag), 64'(c - 3));
        check_eq($sformatf("b2b_data_%0d", c), bus1.mem2proc_data, line_dat(c - 4));
      end else begin
        check_eq($sformatf("b2b_idle_%0d", c), 64'(bus1.mem2proc_tag), 64'd0);
      end
    end

    // Tag wrap across 16 accepted stores; stores never return a tag.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step1(CmdStore, 32'h200 + 32'(i * 8), 64'(i));
      check_eq($sformatf("wrap_resp_%0d", i), 64'(bus1.mem2proc_response),
               (i < 15) ? 64'(i + 1) : 64'd1);
      check_eq($sformatf("wrap_tag_%0d", i), 64'(bus1.mem2proc_tag), 64'd0);
    end
    step1(CmdRsvd, 32'h200, 64'd0);
    check_eq("rsvd_resp", 64'(bus1.mem2proc_response), 64'd0);
    step1(CmdLoad, 32'(8192 * 8), 64'd0);
    check_eq("oor_resp", 64'(bus1.mem2proc_response), 64'd0);
    step1(CmdLoad, 32'(8191 * 8), 64'd0);
    check_eq("last_line_resp", 64'(bus1.mem2proc_response), 64'd2);
    for (int k = 0; k < 4; k++) step1(CmdNone, 32'd0, 64'd0);
    check_eq("last_line_tag", 64'(bus1.mem2proc_tag), 64'd2);

    // Reset with two loads in flight.
    do_reset();
    step1(CmdLoad, 32'h40, 64'd0);
    check_eq("mid_resp1", 64'(bus1.mem2proc_response), 64'd1);
    step1(CmdLoad, 32'h00, 64'd0);
    check_eq("mid_resp2", 64'(bus1.mem2proc_response), 64'd2);
    step1(CmdNone, 32'd0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus1.proc2mem_command = CmdLoad;
    bus1.proc2mem_addr    = 32'h40;
    #1;
    check_eq("mid_rst_resp", 64'(bus1.mem2proc_response), 64'd0);
    check_eq("mid_rst_tag", 64'(bus1.mem2proc_tag), 64'd0);
    check_eq("mid_rst_data", bus1.mem2proc_data, 64'd0);
    @(negedge clk);
    #1;
    check_eq("mid_rst_tag2", 64'(bus1.mem2proc_tag), 64'd0);
    @(negedge clk);
    bus1.proc2mem_command = CmdNone;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step1(CmdNone, 32'd0, 64'd0);
      check_eq($sformatf("stale_tag_%0d", k), 64'(bus1.mem2proc_tag), 64'd0);
    end
    step1(CmdLoad, 32'h40, 64'd0);
    check_eq("post_rst_resp", 64'(bus1.mem2proc_response), 64'd1);
    for (int k = 0; k < 4; k++) step1(CmdNone, 32'd0, 64'd0);
    check_eq("post_rst_tag", 64'(bus1.mem2proc_tag), 64'd1);
    check_eq("post_rst_data", bus1.mem2proc_data, D1);

    // Throttling and address rejection on dut2.
    for (int c = 0; c < 13; c++) begin
      step2(vecs[c].cmd, vecs[c].addr, D2);
      check_eq($sformatf("gap_resp_%0d", c), 64'(bus2.mem2proc_response), 64'(vecs[c].resp));
      check_eq($sformatf("gap_tag_%0d", c), 64'(bus2.mem2proc_tag), 64'(vecs[c].tag));
      if (vecs[c].chk_dat) check_eq($sformatf("gap_data_%0d", c), bus2.mem2proc_data, D2);
      else if (vecs[c].tag == 4'd0)
        check_eq($sformatf("gap_zdata_%0d", c), bus2.mem2proc_data, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_LINES, default 8192: number of 64-bit storage lines, addressed by byte address.
REQ-002 Parameter LATENCY, default 4: cycles from load acceptance to data return; legal range 1..8.
REQ-003 Parameter GAP, default 0: rejection cycles forced after each accepted command; legal range 0..7.
REQ-004 Port clk  in  1  single clock; all state updates on posedge clk.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port proc2mem_command  in  2  request command: 0 BUS_NONE, 1 BUS_LOAD, 2 BUS_STORE, 3 reserved and treated as BUS_NONE.
REQ-007 Port proc2mem_addr  in  32  request byte address.
REQ-008 Port proc2mem_data  in  64  store data.
REQ-009 Port mem2proc_response  out  4  acceptance tag, same cycle as the request; 0 means rejected or idle.
REQ-010 Port mem2proc_data  out  64  load return data; valid only while mem2proc_tag != 0.
REQ-011 Port mem2proc_tag  out  4  tag of the load whose data is returned this cycle; 0 means no return.

Function
REQ-012 Accept condition, all required: reset deasserted; command LOAD or STORE; addr[2:0] == 0; addr[31:3] < MEM_LINES; FSM in READY.
REQ-013 Response: combinational; equals the tag counter value when the accept condition holds, otherwise 0.
REQ-014 Tag counter: 4 bits; reset value 1; increments on every accept; after 15 it becomes 1, so tag 0 is never issued.
REQ-015 Store: writes proc2mem_data to line addr[31:3] on the accepting edge; full 64-bit write only; no tag is ever returned for a store.
REQ-016 Load: reads line addr[31:3] on the accepting edge; captures {tag, data} into stage 0 of a LATENCY-deep delay line.
REQ-017 Return timing: load accepted in cycle N drives mem2proc_tag and mem2proc_data in cycle N+LATENCY for exactly one cycle.
REQ-018 Delay line: advances every cycle and never stalls; at most one accept per cycle, so at most one return per cycle and no return collisions.
REQ-019 Idle return outputs: mem2proc_tag = 0 and mem2proc_data = 0 whenever no return is valid.
REQ-020 Ordering: a load accepted the cycle after a store to the same line returns the stored data. A load and a store are never accepted in the same cycle.
REQ-021 Out-of-range or misaligned request: rejected with response 0; no memory write; no tag consumed; FSM unchanged.
REQ-022 FSM states: READY and THROTTLE.
REQ-023 READY -> THROTTLE on an accept when GAP > 0, with the gap counter loaded to GAP.
REQ-024 In THROTTLE the gap counter decrements each cycle; THROTTLE -> READY when the counter reaches 0; requests in THROTTLE get response 0.
REQ-025 When GAP == 0 the FSM stays in READY permanently.
REQ-026 Rejected requests have no side effects; the requester retries by re-presenting the request.

Reset
REQ-027 While reset is low: mem2proc_response, mem2proc_tag and mem2proc_data are 0, regardless of the clock.
REQ-028 Assertion of reset clears every delay-line valid bit, sets the tag counter to 1, the FSM to READY and the gap counter to 0.
REQ-029 Storage contents are not cleared by reset and may be preloaded by the bench before reset is released.
REQ-030 Reset asserted with loads in flight discards those loads; no stale tag appears after release.

Verification
REQ-031 Store then load, with LATENCY=4, GAP=0:
- STORE addr 0x40, data 0xDEADBEEF_01234567 -> response 1.
- Next cycle, LOAD addr 0x40 -> response 2.
- 4 cycles later -> tag 2 with data 0xDEADBEEF_01234567, for one cycle.
REQ-032 Back-to-back loads: LOADs in cycles 0..3 -> responses 1..4 -> returns with tags 1..4 in cycles 4..7, in order, with no gaps.
REQ-033 Tag wrap: 16 consecutive accepted commands -> responses 1..15, then 1; tag 0 never issued.
REQ-034 Rejects with GAP=2:
- Accepted LOAD -> next two requests get response 0.
- Third request -> accepted.
- Misaligned addr 0x44 -> response 0.
- addr MEM_LINES*8 -> response 0.
REQ-035 Reset mid-flight: 2 loads outstanding, reset low for 1 cycle -> all outputs 0; no return with either tag afterwards; the next accept gets response 1.
